// File: rtl/digit_entry_ctrl.sv
// Write controller for the eight-digit seven-segment display: debounces the load
// and clear buttons and turns each accepted press into a latch write sequence.
module digit_entry_ctrl #(
  parameter int DEB_W    = 16,
  parameter int DEB_MAX  = 50000,
  parameter int WR_PULSE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw,
  input  logic       clr_raw,
  input  logic [3:0] sw_data,
  output logic [3:0] wr_data,
  output logic [2:0] wr_sel,
  output logic       wr_en,
  output logic       busy,
  output logic [2:0] ptr
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, RELEASE, CSETUP, CSTROBE, CRELEASE
  } state_t;

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_MAX - 1);
  localparam logic [3:0]       PULSE_LAST = 4'(WR_PULSE - 1);

  // Index 0 = load button, index 1 = clear button.
  logic [1:0]       raw;
  logic [1:0]       sync1, sync2, deb, deb_d;
  logic [DEB_W-1:0] dcnt [2];
  logic             key_ev, clr_ev;

  assign raw    = {clr_raw, key_raw};
  assign key_ev = deb[0] & ~deb_d[0];
  assign clr_ev = deb[1] & ~deb_d[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_LAST) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  // Write strobe: wr_data/wr_sel settle one cycle before wr_en rises, wr_en
  // stays high WR_PULSE cycles, and they are held one more cycle after it falls.
  state_t     state, state_nx;
  logic [3:0] pcnt, pcnt_nx;
  logic [2:0] ptr_nx;
  logic [3:0] data_nx;

  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt;
    ptr_nx   = ptr;
    data_nx  = wr_data;
    case (state)
      IDLE: begin
        if (clr_ev) begin
          state_nx = CSETUP;
          ptr_nx   = 3'd0;
          data_nx  = 4'd0;
        end else if (key_ev) begin
          state_nx = SETUP;
          data_nx  = sw_data;
        end
      end
      SETUP: begin
        state_nx = STROBE;
        pcnt_nx  = 4'd0;
      end
      STROBE: begin
        if (pcnt == PULSE_LAST) state_nx = RELEASE;
        else                    pcnt_nx  = pcnt + 4'd1;
      end
      RELEASE: begin
        state_nx = IDLE;
        ptr_nx   = ptr + 3'd1;
      end
      CSETUP: begin
        state_nx = CSTROBE;
        pcnt_nx  = 4'd0;
      end
      CSTROBE: begin
        if (pcnt == PULSE_LAST) state_nx = CRELEASE;
        else                    pcnt_nx  = pcnt + 4'd1;
      end
      CRELEASE: begin
        if (ptr == 3'd7) begin
          state_nx = IDLE;
          ptr_nx   = 3'd0;
        end else begin
          state_nx = CSETUP;
          ptr_nx   = ptr + 3'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pcnt    <= '0;
      ptr     <= '0;
      wr_data <= '0;
      wr_sel  <= '0;
      wr_en   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      pcnt    <= pcnt_nx;
      ptr     <= ptr_nx;
      wr_data <= data_nx;
      wr_sel  <= ptr_nx;
      wr_en   <= (state_nx == STROBE) || (state_nx == CSTROBE);
      busy    <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Bench for digit_entry_ctrl with short debounce (DEB_MAX=4) and WR_PULSE=2.
module tb_digit_entry_ctrl;

  logic       clk;
  logic       rst;
  logic       key_raw;
  logic       clr_raw;
  logic [3:0] sw_data;
  logic [3:0] wr_data;
  logic [2:0] wr_sel;
  logic       wr_en;
  logic       busy;
  logic [2:0] ptr;

  int tests = 0;
  int fails = 0;
  logic [6:0] exp_q[$];

  digit_entry_ctrl #(.DEB_W(16), .DEB_MAX(4), .WR_PULSE(2)) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw), .clr_raw(clr_raw),
    .sw_data(sw_data), .wr_data(wr_data), .wr_sel(wr_sel),
    .wr_en(wr_en), .busy(busy), .ptr(ptr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_wait(input logic k, input logic c, input bit flip, output int bc);
    bit seen;
    seen    = 1'b0;
    key_raw = k;
    clr_raw = c;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("busy_start", 32'(seen), 32'd1);
    bc = 0;
    if (seen) begin
      if (flip) sw_data = ~sw_data;
      while (busy && bc < 200) begin
        bc++;
        @(negedge clk);
      end
    end
    key_raw = 1'b0;
    clr_raw = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Scoreboard: every completed wr_en pulse is matched against exp_q
  bit         in_pulse = 1'b0;
  int         plen;
  logic [2:0] cap_sel;
  logic [3:0] cap_data;
  logic [6:0] exp_w;

  always @(negedge clk) begin
    if (!rst) begin
      in_pulse = 1'b0;
    end else begin
      if (wr_en) check("en_while_busy", 32'(busy), 32'd1);
      if (wr_en && !in_pulse) begin
        in_pulse = 1'b1;
        plen     = 1;
        cap_sel  = wr_sel;
        cap_data = wr_data;
      end else if (wr_en && in_pulse) begin
        plen++;
        check("sel_stable", 32'(wr_sel), 32'(cap_sel));
        check("data_stable", 32'(wr_data), 32'(cap_data));
      end else if (!wr_en && in_pulse) begin
        in_pulse = 1'b0;
        check("pulse_len", 32'(plen), 32'd2);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: sel=%0d data=%0h, none expected", cap_sel, cap_data);
        end else begin
          exp_w = exp_q.pop_front();
          if ({cap_sel, cap_data} !== exp_w) begin
            fails++;
            $display("FAIL write: got sel=%0d data=%0h expected sel=%0d data=%0h",
                     cap_sel, cap_data, exp_w[6:4], exp_w[3:0]);
          end
        end
      end
    end
  end

  typedef struct {
    logic [3:0] sw;
    logic [2:0] exp_sel;
    logic [3:0] exp_data;
    logic [2:0] exp_ptr;
  } vec_t;

  vec_t vecs[9];
  int   bc;
  bit   bounce_busy;
  bit   seen_en;

  initial begin
    vecs[0] = '{4'h0, 3'd0, 4'h0, 3'd1};
    vecs[1] = '{4'h1, 3'd1, 4'h1, 3'd2};
    vecs[2] = '{4'h2, 3'd2, 4'h2, 3'd3};
    vecs[3] = '{4'h3, 3'd3, 4'h3, 3'd4};
    vecs[4] = '{4'h4, 3'd4, 4'h4, 3'd5};
    vecs[5] = '{4'h5, 3'd5, 4'h5, 3'd6};
    vecs[6] = '{4'h6, 3'd6, 4'h6, 3'd7};
    vecs[7] = '{4'h7, 3'd7, 4'h7, 3'd0};
    vecs[8] = '{4'hA, 3'd0, 4'hA, 3'd1};

    // Reset held with key pressed: outputs quiet, one write after release
    rst     = 1'b0;
    key_raw = 1'b1;
    clr_raw = 1'b0;
    sw_data = 4'h9;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ptr", 32'(ptr), 32'd0);
    check("rst_wr_sel", 32'(wr_sel), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b1;
    exp_q.push_back({3'd0, 4'h9});
    press_wait(1'b1, 1'b0, 1'b0, bc);
    check("rst_load_busy_len", 32'(bc), 32'd4);
    check("rst_load_ptr", 32'(ptr), 32'd1);

    // Bounce: 2-cycle toggles never qualify, then a held press writes once
    do_reset();
    sw_data     = 4'h5;
    bounce_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key_raw = ~key_raw;
      repeat (2) begin
        @(negedge clk);
        if (busy) bounce_busy = 1'b1;
      end
    end
    check("bounce_no_event", 32'(bounce_busy), 32'd0);
    exp_q.push_back({3'd0, 4'h5});
    press_wait(1'b1, 1'b0, 1'b0, bc);
    check("bounce_busy_len", 32'(bc), 32'd4);
    check("bounce_ptr", 32'(ptr), 32'd1);

    // Wrap: table of loads walks all eight digits and back to 0
    do_reset();
    for (int i = 0; i < 9; i++) begin
      sw_data = vecs[i].sw;
      exp_q.push_back({vecs[i].exp_sel, vecs[i].exp_data});
      press_wait(1'b1, 1'b0, 1'b0, bc);
      check("wrap_busy_len", 32'(bc), 32'd4);
      check("wrap_ptr", 32'(ptr), 32'(vecs[i].exp_ptr));
    end
    check("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Two more loads bring ptr to 3, then clear sweeps all digits
    sw_data = 4'hD;
    exp_q.push_back({3'd1, 4'hD});
    press_wait(1'b1, 1'b0, 1'b0, bc);
    sw_data = 4'hE;
    exp_q.push_back({3'd2, 4'hE});
    press_wait(1'b1, 1'b0, 1'b0, bc);
    check("pre_clear_ptr", 32'(ptr), 32'd3);
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 4'h0});
    press_wait(1'b0, 1'b1, 1'b0, bc);
    check("clear_busy_len", 32'(bc), 32'd32);
    check("clear_ptr", 32'(ptr), 32'd0);
    check("clear_drained", 32'(exp_q.size()), 32'd0);

    // Key and clear accepted in the same cycle: clear only
    sw_data = 4'h6;
    exp_q.push_back({3'd0, 4'h6});
    press_wait(1'b1, 1'b0, 1'b0, bc);
    check("coll_pre_ptr", 32'(ptr), 32'd1);
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 4'h0});
    press_wait(1'b1, 1'b1, 1'b0, bc);
    check("coll_busy_len", 32'(bc), 32'd32);
    check("coll_ptr", 32'(ptr), 32'd0);
    check("coll_drained", 32'(exp_q.size()), 32'd0);

    // Key pressed during a clear is discarded
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 4'h0});
    clr_raw = 1'b1;
    seen_en = 1'b0;
    for (int t = 0; t < 40 && !seen_en; t++) begin
      @(negedge clk);
      if (busy) seen_en = 1'b1;
    end
    check("kdc_busy_start", 32'(seen_en), 32'd1);
    key_raw = 1'b1;
    bc = 1;
    while (busy && bc < 200) begin
      @(negedge clk);
      if (busy) bc++;
    end
    check("kdc_busy_len", 32'(bc), 32'd32);
    repeat (12) @(negedge clk);
    key_raw = 1'b0;
    clr_raw = 1'b0;
    repeat (12) @(negedge clk);
    check("kdc_busy", 32'(busy), 32'd0);
    check("kdc_ptr", 32'(ptr), 32'd0);
    check("kdc_drained", 32'(exp_q.size()), 32'd0);

    // sw_data changed after capture does not alter the write
    sw_data = 4'h3;
    exp_q.push_back({3'd0, 4'h3});
    press_wait(1'b1, 1'b0, 1'b1, bc);
    check("swchg_ptr", 32'(ptr), 32'd1);
    check("swchg_drained", 32'(exp_q.size()), 32'd0);

    // Reset while wr_en is high: outputs drop without a clock edge
    sw_data = 4'h7;
    key_raw = 1'b1;
    seen_en = 1'b0;
    for (int t = 0; t < 40 && !seen_en; t++) begin
      @(negedge clk);
      if (wr_en) seen_en = 1'b1;
    end
    check("mid_wr_en_seen", 32'(seen_en), 32'd1);
    key_raw = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_wr_en", 32'(wr_en), 32'd0);
    check("mid_ptr", 32'(ptr), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_post_busy", 32'(busy), 32'd0);
    check("mid_post_ptr", 32'(ptr), 32'd0);
    sw_data = 4'h2;
    exp_q.push_back({3'd0, 4'h2});
    press_wait(1'b1, 1'b0, 1'b0, bc);
    check("mid_post_load_ptr", 32'(ptr), 32'd1);

    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
